// File: rtl/alu.sv
// RV32I execute-stage ALU: arithmetic, logic, compare and shift with a
// one-cycle registered result and a zero flag for branch resolution.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [SHW-1:0]   shamt;
  logic        [WIDTH-1:0] res_p0;

  // Arithmetic right shift kept signed end to end so the fill follows A's sign.
  function automatic logic [WIDTH-1:0] sra(input logic signed [WIDTH-1:0] v,
                                           input logic [SHW-1:0] sh);
    logic signed [WIDTH-1:0] t;
    t = v >>> sh;
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] flag(input logic f);
    return {{(WIDTH-1){1'b0}}, f};
  endfunction

  assign a_s   = A;
  assign b_s   = B;
  assign shamt = B[SHW-1:0];

  // Stage p0: combinational next result
  always_comb begin
    res_p0 = '0;
    case (ALUOp)
      OP_AND:  res_p0 = A & B;
      OP_OR:   res_p0 = A | B;
      OP_ADD:  res_p0 = A + B;
      OP_XOR:  res_p0 = A ^ B;
      OP_SLL:  res_p0 = A << shamt;
      OP_SRL:  res_p0 = A >> shamt;
      OP_SUB:  res_p0 = A - B;
      OP_SLT:  res_p0 = flag(a_s < b_s);
      OP_SLTU: res_p0 = flag(A < B);
      OP_SRA:  res_p0 = sra(a_s, shamt);
      OP_NOR:  res_p0 = ~(A | B);
      default: res_p0 = '0;
    endcase
  end

  // Stage p1: registered outputs; zero derives from the same next value
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b1;
    end else begin
      result <= res_p0;
      zero   <= (res_p0 == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan cases plus randomized operations
// compared against a behavioural model of the RV32I ALU rules.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUOp;
  logic [31:0] result;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .ALUOp  (ALUOp),
    .result (result),
    .zero   (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = b % 32;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = 32'(longint'(a) + longint'(b));
      4'd3:  r = a ^ b;
      4'd4:  r = 32'(longint'(a) * (longint'(1) << sh));
      4'd5:  r = a / (32'd1 << sh);
      4'd6:  r = 32'(longint'(a) - longint'(b));
      4'd7:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:  r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd9:  r = a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      4'd12: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Apply one operation, clock it, check result and zero against a given value.
  task automatic run_exp(input string tag, input logic rst, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    reset = rst;
    ALUOp = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    check(tag, result, exp);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    logic [31:0] ra, rb, e;
    logic [3:0]  rop;
    logic        rr;

    reset = 1'b1; ALUOp = 4'd2; A = 32'd1; B = 32'd2;
    run_exp("reset1", 1'b1, 4'd2, 32'd1, 32'd2, 32'd0);
    run_exp("reset_hold", 1'b1, 4'd3, 32'h1234, 32'h1, 32'd0);
    run_exp("after_reset_add", 1'b0, 4'd2, 32'd10, 32'd10, 32'd20);

    run_exp("add", 1'b0, 4'd2, 32'd30, 32'd10, 32'd40);
    run_exp("sub", 1'b0, 4'd6, 32'd30, 32'd10, 32'd20);
    run_exp("sub_eq", 1'b0, 4'd6, 32'd10, 32'd10, 32'd0);
    run_exp("add_wrap", 1'b0, 4'd2, 32'hFFFFFFFF, 32'd1, 32'd0);
    run_exp("sub_wrap", 1'b0, 4'd6, 32'd0, 32'd1, 32'hFFFFFFFF);

    run_exp("and", 1'b0, 4'd0, 32'h0FFC, 32'h0007, 32'h0004);
    run_exp("or", 1'b0, 4'd1, 32'h0FFC, 32'h0007, 32'h0FFF);
    run_exp("xor", 1'b0, 4'd3, 32'h0FFC, 32'h0007, 32'h0FFB);
    run_exp("nor", 1'b0, 4'd12, 32'h0FFC, 32'h0007, 32'hFFFFF000);

    run_exp("slt_neg", 1'b0, 4'd7, 32'hFFFFFFFF, 32'd1, 32'd1);
    run_exp("sltu_big", 1'b0, 4'd8, 32'hFFFFFFFF, 32'd1, 32'd0);
    run_exp("slt_min", 1'b0, 4'd7, 32'h80000000, 32'd1, 32'd1);
    run_exp("slt_eq", 1'b0, 4'd7, 32'd5, 32'd5, 32'd0);
    run_exp("sltu_lt", 1'b0, 4'd8, 32'd1, 32'hFFFFFFFF, 32'd1);
    run_exp("slt_pos", 1'b0, 4'd7, 32'd1, 32'hFFFFFFFF, 32'd0);

    run_exp("sll4", 1'b0, 4'd4, 32'h80000001, 32'd4, 32'h00000010);
    run_exp("srl4", 1'b0, 4'd5, 32'h80000001, 32'd4, 32'h08000000);
    run_exp("sra4", 1'b0, 4'd9, 32'h80000001, 32'd4, 32'hF8000000);
    run_exp("sll33", 1'b0, 4'd4, 32'h80000001, 32'h21, 32'h00000002);
    run_exp("srl33", 1'b0, 4'd5, 32'h80000001, 32'h21, 32'h40000000);
    run_exp("sra33", 1'b0, 4'd9, 32'h80000001, 32'h21, 32'hC0000000);
    run_exp("sll0", 1'b0, 4'd4, 32'h80000001, 32'd0, 32'h80000001);
    run_exp("srl0", 1'b0, 4'd5, 32'h80000001, 32'd0, 32'h80000001);
    run_exp("sra0", 1'b0, 4'd9, 32'h80000001, 32'd0, 32'h80000001);
    run_exp("sra_pos", 1'b0, 4'd9, 32'h40000000, 32'd31, 32'd0);

    run_exp("illegal_f", 1'b0, 4'hF, 32'hDEADBEEF, 32'h1, 32'd0);
    run_exp("illegal_a", 1'b0, 4'hA, 32'h12345678, 32'h9, 32'd0);
    run_exp("pre_reset", 1'b0, 4'd1, 32'h1, 32'h2, 32'h3);
    run_exp("mid_reset", 1'b1, 4'd1, 32'h1, 32'h2, 32'd0);
    run_exp("post_reset", 1'b0, 4'd2, 32'h5, 32'h6, 32'hB);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(0, 40));
        1: rb = ra;
        default: rb = $urandom;
      endcase
      rop = 4'($urandom_range(0, 15));
      rr  = ($urandom_range(0, 19) == 0);
      e   = rr ? 32'd0 : model(rop, ra, rb);
      run_exp($sformatf("rand%0d_op%0d", i, rop), rr, rop, ra, rb, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
